// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared BCD digit types, limits and carry/borrow helpers for the stopwatch.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        FIELD_MIN = 1'b0,
        FIELD_SEC = 1'b1
    } field_e;

    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Result is {carry, digit}: the digit wraps to 0 after reaching lim.
    function automatic logic [4:0] bcd_inc(input bcd_t d, input bcd_t lim);
        if (d >= lim) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // Result is {borrow, digit}: the digit wraps to lim below 0.
    function automatic logic [4:0] bcd_dec(input bcd_t d, input bcd_t lim);
        if (d == 4'd0) begin
            return {1'b1, lim};
        end
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// rtl/sw_tick_gen.sv - free-running divider producing registered 2 Hz and 1 Hz enable pulses.
module sw_tick_gen #(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic reset,
    output logic en_2hz,
    output logic en_1hz
);

    localparam int HALF = CLK_HZ / 2;
    localparam int DW   = $clog2(HALF);

    logic [DW-1:0] r_div;
    logic          r_half;
    logic          r_en_2hz;
    logic          r_en_1hz;
    logic          w_term;

    assign w_term = (r_div == DW'(HALF - 1));

    // r_half marks that the next terminal cycle completes a full second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_half   <= 1'b0;
            r_en_2hz <= 1'b0;
            r_en_1hz <= 1'b0;
        end else begin
            r_div    <= w_term ? '0 : r_div + DW'(1);
            r_en_2hz <= w_term;
            r_en_1hz <= w_term & r_half;
            if (w_term) begin
                r_half <= ~r_half;
            end
        end
    end

    assign en_2hz = r_en_2hz;
    assign en_1hz = r_en_1hz;

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - mm:ss BCD stopwatch with up/down count, pause, field adjust and blink.
// Optional lap freeze of the displayed digits is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int MAX_MIN      = 59,
    parameter int RUN_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       adjust,
    input  logic       select,
    input  logic       dir,
    input  logic       lap,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       en_1hz,
    output logic       en_2hz,
    output logic       running,
    output logic       done,
    output logic       blank_min,
    output logic       blank_sec
);

    localparam bcd_t MAX_MT = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_MO = bcd_t'(MAX_MIN % 10);

    logic       w_en_2hz, w_en_1hz, w_pause_rise;
    bcd_t       r_mt, r_mo, r_st, r_so;
    bcd_t       w_mt_n, w_mo_n, w_st_n, w_so_n;
    logic       r_running, r_done, r_blink, r_pause_d;
    logic       w_run_n, w_done_n, w_stop;
    logic [4:0] w_so_inc, w_st_inc, w_mo_inc, w_so_dec, w_st_dec, w_mo_dec;
    logic       w_min_max, w_zero, w_one;

    sw_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en_2hz (w_en_2hz),
        .en_1hz (w_en_1hz)
    );

    assign w_pause_rise = pause & ~r_pause_d;
    assign w_so_inc  = bcd_inc(r_so, DIGIT_MAX);
    assign w_st_inc  = bcd_inc(r_st, SEC_MAX_TENS);
    assign w_mo_inc  = bcd_inc(r_mo, DIGIT_MAX);
    assign w_so_dec  = bcd_dec(r_so, DIGIT_MAX);
    assign w_st_dec  = bcd_dec(r_st, SEC_MAX_TENS);
    assign w_mo_dec  = bcd_dec(r_mo, DIGIT_MAX);
    assign w_min_max = (r_mt == MAX_MT) && (r_mo == MAX_MO);
    assign w_zero    = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
    assign w_one     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd1);

    always_comb begin
        w_mt_n   = r_mt;
        w_mo_n   = r_mo;
        w_st_n   = r_st;
        w_so_n   = r_so;
        w_stop   = 1'b0;
        w_done_n = 1'b0;
        if (adjust) begin
            if (w_en_2hz) begin
                if (field_e'(select) == FIELD_SEC) begin
                    w_so_n = w_so_inc[3:0];
                    if (w_so_inc[4]) w_st_n = w_st_inc[3:0];
                end else if (w_min_max) begin
                    w_mt_n = 4'd0;
                    w_mo_n = 4'd0;
                end else begin
                    w_mo_n = w_mo_inc[3:0];
                    if (w_mo_inc[4]) w_mt_n = r_mt + 4'd1;
                end
            end
        end else if (r_running && w_en_1hz) begin
            if (!dir) begin
                w_so_n = w_so_inc[3:0];
                if (w_so_inc[4]) w_st_n = w_st_inc[3:0];
                if (w_so_inc[4] && w_st_inc[4]) begin
                    if (w_min_max) begin
                        w_mt_n = 4'd0;
                        w_mo_n = 4'd0;
                    end else begin
                        w_mo_n = w_mo_inc[3:0];
                        if (w_mo_inc[4]) w_mt_n = r_mt + 4'd1;
                    end
                end
            end else if (w_zero) begin
                w_stop = 1'b1;
            end else begin
                w_so_n = w_so_dec[3:0];
                if (w_so_dec[4]) begin
                    w_st_n = w_st_dec[3:0];
                    if (w_st_dec[4]) begin
                        w_mo_n = w_mo_dec[3:0];
                        if (w_mo_dec[4]) w_mt_n = r_mt - 4'd1;
                    end
                end
                if (w_one) begin
                    w_stop   = 1'b1;
                    w_done_n = 1'b1;
                end
            end
        end
        // The tick above already used the pre-toggle run state.
        w_run_n = w_pause_rise ? ~r_running : r_running;
        if (w_stop) w_run_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_running <= (RUN_ON_RESET != 0);
            r_done    <= 1'b0;
            r_blink   <= 1'b0;
            r_pause_d <= 1'b0;
        end else begin
            r_mt      <= w_mt_n;
            r_mo      <= w_mo_n;
            r_st      <= w_st_n;
            r_so      <= w_so_n;
            r_running <= w_run_n;
            r_done    <= w_done_n;
            r_pause_d <= pause;
            if (!adjust) begin
                r_blink <= 1'b0;
            end else if (w_en_2hz) begin
                r_blink <= ~r_blink;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_lap_d, r_frozen;
    bcd_t r_lap_mt, r_lap_mo, r_lap_st, r_lap_so;
    logic w_show_lap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_d  <= 1'b0;
            r_frozen <= 1'b0;
            r_lap_mt <= 4'd0;
            r_lap_mo <= 4'd0;
            r_lap_st <= 4'd0;
            r_lap_so <= 4'd0;
        end else begin
            r_lap_d <= lap;
            if (lap & ~r_lap_d) begin
                r_frozen <= ~r_frozen;
                if (!r_frozen) begin
                    r_lap_mt <= r_mt;
                    r_lap_mo <= r_mo;
                    r_lap_st <= r_st;
                    r_lap_so <= r_so;
                end
            end
        end
    end

    assign w_show_lap = r_frozen & ~adjust;
    assign min_tens   = w_show_lap ? r_lap_mt : r_mt;
    assign min_ones   = w_show_lap ? r_lap_mo : r_mo;
    assign sec_tens   = w_show_lap ? r_lap_st : r_st;
    assign sec_ones   = w_show_lap ? r_lap_so : r_so;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign min_tens     = r_mt;
    assign min_ones     = r_mo;
    assign sec_tens     = r_st;
    assign sec_ones     = r_so;
`endif

    assign en_1hz    = w_en_1hz;
    assign en_2hz    = w_en_2hz;
    assign running   = r_running;
    assign done      = r_done;
    assign blank_min = adjust & ~select & r_blink;
    assign blank_sec = adjust & select & r_blink;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core with a seconds-based reference model.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 8;
    localparam int HALF    = CLK_HZ / 2;
    localparam int MAX_MIN = 2;
    localparam int SPAN    = (MAX_MIN + 1) * 60;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pause = 1'b0, adjust = 1'b0, select = 1'b0, dir = 1'b0, lap = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic en_1hz, en_2hz, running, done, blank_min, blank_sec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN), .RUN_ON_RESET(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .adjust    (adjust),
        .select    (select),
        .dir       (dir),
        .lap       (lap),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .en_1hz    (en_1hz),
        .en_2hz    (en_2hz),
        .running   (running),
        .done      (done),
        .blank_min (blank_min),
        .blank_sec (blank_sec)
    );

    // Reference model: time kept as a plain count of seconds, cycles since reset release.
    int m_cyc, m_total, m_lap_total;
    bit m_run, m_pd, m_blink, m_done, m_ld, m_frozen;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_total = 0; m_lap_total = 0;
            m_run = 1'b1; m_pd = 1'b0; m_blink = 1'b0; m_done = 1'b0; m_ld = 1'b0; m_frozen = 1'b0;
        end else begin
            bit t1, t2, rise, old, stop;
            int mm, ss;
            t2 = (m_cyc > 0) && (m_cyc % HALF == 0);
            t1 = (m_cyc > 0) && (m_cyc % CLK_HZ == 0);
            rise = pause && !m_pd;
            m_pd = pause;
            old = m_run;
            stop = 1'b0;
            m_done = 1'b0;
`ifdef STOPWATCH_LAP_EN
            if (lap && !m_ld) begin
                if (!m_frozen) m_lap_total = m_total;
                m_frozen = !m_frozen;
            end
`endif
            m_ld = lap;
            if (adjust) begin
                if (t2) begin
                    m_blink = !m_blink;
                    mm = m_total / 60;
                    ss = m_total % 60;
                    if (select) ss = (ss + 1) % 60;
                    else        mm = (mm + 1) % (MAX_MIN + 1);
                    m_total = mm * 60 + ss;
                end
            end else begin
                m_blink = 1'b0;
                if (old && t1) begin
                    if (!dir) m_total = (m_total + 1) % SPAN;
                    else if (m_total == 0) stop = 1'b1;
                    else begin
                        m_total = m_total - 1;
                        if (m_total == 0) begin
                            stop = 1'b1;
                            m_done = 1'b1;
                        end
                    end
                end
            end
            m_run = rise ? !old : old;
            if (stop) m_run = 1'b0;
            m_cyc = m_cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dig();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            int dt;
            bit e1, e2;
            dt = (m_frozen && !adjust) ? m_lap_total : m_total;
            e2 = (m_cyc > 0) && (m_cyc % HALF == 0);
            e1 = (m_cyc > 0) && (m_cyc % CLK_HZ == 0);
            chk("model_digits", {16'h0, dig()},
                {16'h0, 4'(dt / 600), 4'((dt / 60) % 10), 4'((dt % 60) / 10), 4'(dt % 10)});
            chk("model_flags", {26'h0, en_1hz, en_2hz, running, done, blank_min, blank_sec},
                {26'h0, e1, e2, m_run, m_done, adjust & !select & m_blink, adjust & select & m_blink});
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_e1();
        int n = 0;
        do begin nxt(); n++; end while (!en_1hz && n < 20);
        chk("wait_en_1hz", {31'h0, en_1hz}, 32'h1);
    endtask

    task automatic wait_e2();
        int n = 0;
        do begin nxt(); n++; end while (!en_2hz && n < 10);
        chk("wait_en_2hz", {31'h0, en_2hz}, 32'h1);
    endtask

    task automatic wait_total(input int t);
        int n = 0;
        while (m_total != t && n < 1000) begin nxt(); n++; end
        chk("wait_total", m_total, t);
    endtask

    task automatic wait_sec(input int s);
        int n = 0;
        while ((m_total % 60) != s && n < 1000) begin nxt(); n++; end
        chk("wait_sec", m_total % 60, s);
    endtask

    task automatic wait_min(input int m);
        int n = 0;
        while ((m_total / 60) != m && n < 1000) begin nxt(); n++; end
        chk("wait_min", m_total / 60, m);
    endtask

    task automatic pulse_pause();
        pause = 1'b1; nxt(); nxt(); pause = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; nxt(); nxt(); lap = 1'b0;
    endtask

    initial begin
        int cnt1;
        int dcnt;
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (i == 5) begin
                chk("reset_digits", {16'h0, dig()}, 32'h0);
                chk("reset_flags", {26'h0, en_1hz, en_2hz, running, done, blank_min, blank_sec}, 32'h08);
            end
        end
        reset = 1'b0;

        cnt1 = 0;
        for (int i = 0; i < 241; i++) begin
            nxt();
            if (en_1hz) cnt1++;
        end
        chk("free_run_digits", {16'h0, dig()}, 32'h0030);
        chk("free_run_en1hz_count", cnt1, 30);

        adjust = 1'b1; select = 1'b0;
        wait_min(2);
        select = 1'b1;
        wait_sec(59);
        chk("preload_digits", {16'h0, dig()}, 32'h0259);
        adjust = 1'b0;
        wait_e1();
        nxt();
        chk("wrap_digits", {16'h0, dig()}, 32'h0000);
        chk("wrap_running", {31'h0, running}, 32'h1);

        wait_total(2);
        dir = 1'b1;
        wait_e1(); nxt();
        chk("down_0001", {16'h0, dig()}, 32'h0001);
        wait_e1(); nxt();
        chk("down_0000", {16'h0, dig()}, 32'h0000);
        chk("down_done", {31'h0, done}, 32'h1);
        chk("down_stop", {31'h0, running}, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            nxt();
            if (done) dcnt++;
        end
        chk("down_single_done", dcnt, 0);
        chk("down_hold", {16'h0, dig()}, 32'h0000);
        wait_e1();
        pulse_pause();
        chk("zero_restart_running", {31'h0, running}, 32'h1);
        wait_e1(); nxt();
        chk("zero_tick_running", {31'h0, running}, 32'h0);
        chk("zero_tick_no_done", {31'h0, done}, 32'h0);
        chk("zero_tick_digits", {16'h0, dig()}, 32'h0000);

        dir = 1'b0;
        wait_e1();
        pulse_pause();
        wait_total(5);
        pulse_pause();
        chk("pause_running", {31'h0, running}, 32'h0);
        for (int i = 0; i < 5; i++) wait_e1();
        nxt();
        chk("pause_hold", {16'h0, dig()}, 32'h0005);
        pulse_pause();
        wait_e1(); nxt();
        chk("resume_0006", {16'h0, dig()}, 32'h0006);
        wait_e1();
        pause = 1'b1;
        nxt();
        chk("coincident_tick", {16'h0, dig()}, 32'h0007);
        chk("coincident_paused", {31'h0, running}, 32'h0);
        nxt();
        pause = 1'b0;

        adjust = 1'b1; select = 1'b1;
        wait_sec(58);
        chk("adj_0058", {16'h0, dig()}, 32'h0058);
        wait_e2(); nxt();
        chk("adj_0059", {16'h0, dig()}, 32'h0059);
        chk("adj_blank_min", {31'h0, blank_min}, 32'h0);
        wait_e2(); nxt();
        chk("adj_sec_wrap", {16'h0, dig()}, 32'h0000);
        chk("adj_blank_sec", {31'h0, blank_sec}, 32'h1);
        select = 1'b0;
        wait_min(2);
        chk("adj_0200", {16'h0, dig()}, 32'h0200);
        wait_e2(); nxt();
        chk("adj_min_wrap", {16'h0, dig()}, 32'h0000);
        adjust = 1'b0;

        wait_e1();
        pulse_pause();
        wait_total(10);
        pulse_lap();
        wait_total(14);
`ifdef STOPWATCH_LAP_EN
        chk("lap_frozen", {16'h0, dig()}, 32'h0010);
`else
        chk("lap_ignored", {16'h0, dig()}, 32'h0014);
`endif
        pulse_lap();
        chk("lap_release", {16'h0, dig()}, 32'h0014);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
